vcnpu_tile_dispatcher: RTL and testbench

//  In-order tile dispatcher for the VCNPU pipeline. Sits between the producer/addr_gen front end, the DMA engine and LANES consumer_dpm instances.

---
 rtl/vcnpu_tile_dispatcher_pkg.sv | 22 ++
 rtl/vcnpu_tile_dispatcher_if.sv | 41 ++++
 rtl/vcnpu_tile_dispatcher_lane_slot.sv | 42 ++++
 rtl/vcnpu_tile_dispatcher.sv | 191 +++++++++++++++++++
 tb/tb_vcnpu_tile_dispatcher.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vcnpu_tile_dispatcher_pkg.sv
// Shared types for the VCNPU tile dispatcher: slot lifecycle, frame FSM and slot-count helper.
package vcnpu_tile_dispatcher_pkg;

  typedef enum logic [1:0] {
    SlotFree,
    SlotPend,
    SlotFlight,
    SlotReady
  } slot_state_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } fsm_t;

  function automatic int unsigned slot_depth(input int unsigned tag_w);
    return 32'd1 << tag_w;
  endfunction

endpackage

// File: rtl/vcnpu_tile_dispatcher_if.sv
// Front-end, DMA and lane-side signal bundle of the tile dispatcher.
interface vcnpu_tile_dispatcher_if #(
  parameter int unsigned GID_W = 16,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned LANES = 2
);
  logic                   start;
  logic [GID_W-1:0]       groups_total;
  logic                   in_valid;
  logic [GID_W-1:0]       in_gid;
  logic [31:0]            in_base;
  logic [31:0]            in_len;
  logic                   in_ready;
  logic                   dma_issue_valid;
  logic [TAG_W-1:0]       dma_issue_tag;
  logic [31:0]            dma_issue_base;
  logic [31:0]            dma_issue_len;
  logic                   dma_issue_ready;
  logic                   dma_done_valid;
  logic [TAG_W-1:0]       dma_done_tag;
  logic [LANES-1:0]       disp_valid;
  logic [LANES*GID_W-1:0] disp_gid;
  logic [LANES-1:0]       disp_ready;
  logic [TAG_W:0]         occupancy;
  logic                   done;
  logic                   err_bad_tag;

  modport master (
    output start, groups_total, in_valid, in_gid, in_base, in_len,
           dma_issue_ready, dma_done_valid, dma_done_tag, disp_ready,
    input  in_ready, dma_issue_valid, dma_issue_tag, dma_issue_base, dma_issue_len,
           disp_valid, disp_gid, occupancy, done, err_bad_tag
  );

  modport slave (
    input  start, groups_total, in_valid, in_gid, in_base, in_len,
           dma_issue_ready, dma_done_valid, dma_done_tag, disp_ready,
    output in_ready, dma_issue_valid, dma_issue_tag, dma_issue_base, dma_issue_len,
           disp_valid, disp_gid, occupancy, done, err_bad_tag
  );
endinterface

// File: rtl/vcnpu_tile_dispatcher_lane_slot.sv
// One consumer lane output register: holds gid/valid until the consumer accepts it.
module vcnpu_tile_dispatcher_lane_slot #(
  parameter int unsigned GID_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [GID_W-1:0] gid_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [GID_W-1:0] gid_o,
  output logic             empty_next_o
);
  logic             valid_q, valid_d;
  logic [GID_W-1:0] gid_q, gid_d;

  always_comb begin
    valid_d = valid_q;
    gid_d   = gid_q;
    if (load_i) begin
      valid_d = 1'b1;
      gid_d   = gid_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      gid_q   <= '0;
    end else begin
      valid_q <= valid_d;
      gid_q   <= gid_d;
    end
  end

  // Free this cycle, or handing off this cycle so a reload can overlap.
  assign empty_next_o = !valid_q || ready_i;
  assign valid_o      = valid_q;
  assign gid_o        = gid_q;
endmodule

// File: rtl/vcnpu_tile_dispatcher.sv
// In-order tile dispatcher: slot ring with in-order DMA prefetch, out-of-order completion,
// in-order dispatch to the lowest free consumer lane.
module vcnpu_tile_dispatcher
  import vcnpu_tile_dispatcher_pkg::*;
#(
  parameter int unsigned GID_W = 16,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned LANES = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  vcnpu_tile_dispatcher_if.slave bus
);
  localparam int unsigned    Depth    = slot_depth(TAG_W);
  localparam logic [TAG_W:0] DepthCnt = (TAG_W + 1)'(Depth);

  slot_state_t      slot_state_q [Depth];
  slot_state_t      slot_state_d [Depth];
  logic [GID_W-1:0] slot_gid_q   [Depth];
  logic [GID_W-1:0] slot_gid_d   [Depth];
  logic [31:0]      slot_base_q  [Depth];
  logic [31:0]      slot_base_d  [Depth];
  logic [31:0]      slot_len_q   [Depth];
  logic [31:0]      slot_len_d   [Depth];

  logic [TAG_W-1:0] tail_q, tail_d, issue_q, issue_d, head_q, head_d;
  logic [TAG_W:0]   occ_q, occ_d;
  logic [GID_W-1:0] total_q, total_d, accepted_q, accepted_d, retired_q, retired_d;
  fsm_t             fsm_q, fsm_d;
  logic             err_q, err_d, done_q, done_d;

  logic             ready_in, acc_fire, issue_pend, issue_fire, head_ready, disp_fire, found;
  logic [LANES-1:0] lane_valid, lane_free, lane_load, lane_fire;
  logic [GID_W-1:0] lane_gid [LANES];
  logic [GID_W-1:0] retire_cnt;

  assign ready_in   = (fsm_q == StRun) && (occ_q < DepthCnt);
  assign acc_fire   = bus.in_valid && ready_in;
  assign issue_pend = (slot_state_q[issue_q] == SlotPend);
  assign issue_fire = issue_pend && bus.dma_issue_ready;
  assign head_ready = (slot_state_q[head_q] == SlotReady);
  assign disp_fire  = head_ready && (|lane_free);
  assign lane_fire  = lane_valid & bus.disp_ready;

  // Priority encoder: lowest-index lane that is free or handing off this cycle.
  always_comb begin
    found     = 1'b0;
    lane_load = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (disp_fire && lane_free[i] && !found) begin
        lane_load[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      retire_cnt = retire_cnt + GID_W'(lane_fire[i]);
    end
  end

  always_comb begin
    slot_state_d = slot_state_q;
    slot_gid_d   = slot_gid_q;
    slot_base_d  = slot_base_q;
    slot_len_d   = slot_len_q;
    tail_d       = tail_q;
    issue_d      = issue_q;
    head_d       = head_q;
    total_d      = total_q;
    accepted_d   = accepted_q;
    retired_d    = retired_q + retire_cnt;
    err_d        = err_q;
    fsm_d        = fsm_q;

    if (acc_fire) begin
      slot_state_d[tail_q] = SlotPend;
      slot_gid_d[tail_q]   = bus.in_gid;
      slot_base_d[tail_q]  = bus.in_base;
      slot_len_d[tail_q]   = bus.in_len;
      tail_d               = tail_q + TAG_W'(1);
      accepted_d           = accepted_q + GID_W'(1);
    end

    if (issue_fire) begin
      slot_state_d[issue_q] = SlotFlight;
      issue_d               = issue_q + TAG_W'(1);
    end

    // Only an in-flight slot may complete; anything else is dropped and flagged.
    if (bus.dma_done_valid) begin
      if (slot_state_q[bus.dma_done_tag] == SlotFlight) begin
        slot_state_d[bus.dma_done_tag] = SlotReady;
      end else begin
        err_d = 1'b1;
      end
    end

    if (disp_fire) begin
      slot_state_d[head_q] = SlotFree;
      head_d               = head_q + TAG_W'(1);
    end

    occ_d = occ_q + (TAG_W + 1)'(acc_fire) - (TAG_W + 1)'(disp_fire);

    unique case (fsm_q)
      StIdle, StDone: begin
        if (bus.start) begin
          fsm_d      = (bus.groups_total == '0) ? StDone : StRun;
          total_d    = bus.groups_total;
          accepted_d = '0;
          retired_d  = '0;
          err_d      = 1'b0;
        end
      end
      StRun: begin
        if (accepted_d == total_q) fsm_d = StDrain;
      end
      StDrain: begin
        if (retired_d == total_q) fsm_d = StDone;
      end
      default: fsm_d = StIdle;
    endcase

    done_d = (fsm_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        slot_state_q[i] <= SlotFree;
        slot_gid_q[i]   <= '0;
        slot_base_q[i]  <= '0;
        slot_len_q[i]   <= '0;
      end
      tail_q     <= '0;
      issue_q    <= '0;
      head_q     <= '0;
      occ_q      <= '0;
      total_q    <= '0;
      accepted_q <= '0;
      retired_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      fsm_q      <= StIdle;
    end else begin
      slot_state_q <= slot_state_d;
      slot_gid_q   <= slot_gid_d;
      slot_base_q  <= slot_base_d;
      slot_len_q   <= slot_len_d;
      tail_q       <= tail_d;
      issue_q      <= issue_d;
      head_q       <= head_d;
      occ_q        <= occ_d;
      total_q      <= total_d;
      accepted_q   <= accepted_d;
      retired_q    <= retired_d;
      err_q        <= err_d;
      done_q       <= done_d;
      fsm_q        <= fsm_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vcnpu_tile_dispatcher_lane_slot #(
      .GID_W(GID_W)
    ) u_lane (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .load_i      (lane_load[i]),
      .gid_i       (slot_gid_q[head_q]),
      .ready_i     (bus.disp_ready[i]),
      .valid_o     (lane_valid[i]),
      .gid_o       (lane_gid[i]),
      .empty_next_o(lane_free[i])
    );
    assign bus.disp_gid[i*GID_W +: GID_W] = lane_gid[i];
  end

  assign bus.in_ready        = ready_in;
  assign bus.dma_issue_valid = issue_pend;
  assign bus.dma_issue_tag   = issue_q;
  assign bus.dma_issue_base  = slot_base_q[issue_q];
  assign bus.dma_issue_len   = slot_len_q[issue_q];
  assign bus.disp_valid      = lane_valid;
  assign bus.occupancy       = occ_q;
  assign bus.done            = done_q;
  assign bus.err_bad_tag     = err_q;
endmodule

// File: tb/tb_vcnpu_tile_dispatcher.sv
// Self-checking bench: gid scoreboard on lane loads, issue-order model, DMA responder model.
module tb_vcnpu_tile_dispatcher;
  localparam int unsigned GID_W = 16;
  localparam int unsigned TAG_W = 3;
  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vcnpu_tile_dispatcher_if #(.GID_W(GID_W), .TAG_W(TAG_W), .LANES(LANES)) bus ();

  vcnpu_tile_dispatcher #(
    .GID_W(GID_W),
    .TAG_W(TAG_W),
    .LANES(LANES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int               due;
    logic [TAG_W-1:0] tag;
  } cmp_t;

  typedef struct {
    logic             start;
    logic [GID_W-1:0] gt;
    logic             dv;
    logic [TAG_W-1:0] dtag;
    logic             err;
    logic             done;
    logic             rdy;
    logic             iv;
    logic [TAG_W:0]   occ;
  } vec_t;

  int               n_checks = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               retired = 0;
  int               dma_lat = 10;
  bit               dma_auto = 1'b0;
  cmp_t             dma_q[$];
  logic [GID_W-1:0] exp_q[$];
  logic [31:0]      m_base[DEPTH];
  logic [31:0]      m_len[DEPTH];
  logic [TAG_W-1:0] m_tail = '0;
  logic [TAG_W-1:0] m_issue = '0;
  logic [LANES-1:0] fresh = '1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // DMA responder: drives completions mid-cycle so they are sampled on the next edge.
  initial begin
    bus.dma_done_valid = 1'b0;
    bus.dma_done_tag   = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (dma_q.size() > 0 && dma_q[0].due <= cyc) begin
        bus.dma_done_valid = 1'b1;
        bus.dma_done_tag   = dma_q[0].tag;
        void'(dma_q.pop_front());
      end else begin
        bus.dma_done_valid = 1'b0;
      end
    end
  end

  // Monitor: model accepts/issues, and compare each newly loaded lane gid in arrival order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fresh = '1;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(bus.in_gid);
          m_base[m_tail] = bus.in_base;
          m_len[m_tail]  = bus.in_len;
          m_tail++;
        end
        if (bus.dma_issue_valid && bus.dma_issue_ready) begin
          check("issue_tag", 32'(bus.dma_issue_tag), 32'(m_issue));
          check("issue_base", bus.dma_issue_base, m_base[m_issue]);
          check("issue_len", bus.dma_issue_len, m_len[m_issue]);
          if (dma_auto) dma_q.push_back('{cyc + dma_lat, bus.dma_issue_tag});
          m_issue++;
        end
        for (int i = 0; i < int'(LANES); i++) begin
          if (bus.disp_valid[i] && fresh[i]) begin
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("disp_gid", 32'(bus.disp_gid[i*GID_W +: GID_W]),
                                        32'(exp_q.pop_front()));
          end
          if (bus.disp_valid[i] && bus.disp_ready[i]) retired++;
          fresh[i] = !(bus.disp_valid[i] && !bus.disp_ready[i]);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n               = 1'b0;
    bus.start           = 1'b0;
    bus.groups_total    = '0;
    bus.in_valid        = 1'b0;
    bus.in_gid          = '0;
    bus.in_base         = '0;
    bus.in_len          = '0;
    bus.dma_issue_ready = 1'b0;
    bus.disp_ready      = '0;
    dma_auto            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dma_q.delete();
    exp_q.delete();
    m_tail  = '0;
    m_issue = '0;
    retired = 0;
    rst_n   = 1'b1;
    tick(1);
  endtask

  task automatic set_desc(input logic [GID_W-1:0] gid);
    bus.in_valid = 1'b1;
    bus.in_gid   = gid;
    bus.in_base  = 32'h1000_0000 + 32'({gid, 6'b0});
    bus.in_len   = 32'd64 + 32'(gid);
  endtask

  task automatic send(input logic [GID_W-1:0] gid);
    set_desc(gid);
    for (int t = 0; t < 300; t++) begin
      if (bus.in_ready) begin
        tick(1);
        bus.in_valid = 1'b0;
        return;
      end
      tick(1);
    end
    check("send_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [GID_W-1:0] gt);
    bus.start        = 1'b1;
    bus.groups_total = gt;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int t = 0; t < budget; t++) begin
      if (bus.done) return;
      tick(1);
    end
    check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    do_reset();

    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_issue_valid", 32'(bus.dma_issue_valid), 32'd0);
    check("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
    check("rst_occupancy", 32'(bus.occupancy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err_bad_tag), 32'd0);

    // Bad-tag / start-sampling vectors: {start, gt, dv, dtag} -> {err, done, rdy, iv, occ}
    tbl[0] = '{1'b0, 16'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{1'b0, 16'd0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[2] = '{1'b1, 16'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[3] = '{1'b0, 16'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[4] = '{1'b0, 16'd0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[5] = '{1'b1, 16'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[6] = '{1'b0, 16'd0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[7] = '{1'b1, 16'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[8] = '{1'b0, 16'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
    for (int k = 0; k < 9; k++) begin
      bus.start        = tbl[k].start;
      bus.groups_total = tbl[k].gt;
      if (tbl[k].dv) dma_q.push_back('{0, tbl[k].dtag});
      tick(1);
      bus.start = 1'b0;
      check($sformatf("vec%0d_err", k), 32'(bus.err_bad_tag), 32'(tbl[k].err));
      check($sformatf("vec%0d_done", k), 32'(bus.done), 32'(tbl[k].done));
      check($sformatf("vec%0d_in_ready", k), 32'(bus.in_ready), 32'(tbl[k].rdy));
      check($sformatf("vec%0d_issue_valid", k), 32'(bus.dma_issue_valid), 32'(tbl[k].iv));
      check($sformatf("vec%0d_occ", k), 32'(bus.occupancy), 32'(tbl[k].occ));
    end

    // In-order DMA with 10-cycle latency, lanes always ready.
    do_reset();
    dma_auto = 1'b1;
    dma_lat  = 10;
    bus.dma_issue_ready = 1'b1;
    bus.disp_ready      = 2'b11;
    start_frame(16'd4);
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) send(16'(i));
    wait_done(200);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_retired", 32'(retired), 32'd4);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t1_occ", 32'(bus.occupancy), 32'd0);
    check("t1_in_ready_done", 32'(bus.in_ready), 32'd0);

    // Fill all slots with DMA stalled; the ninth descriptor waits for a dispatch.
    do_reset();
    bus.disp_ready = 2'b11;
    start_frame(16'd9);
    for (int i = 0; i < 8; i++) send(16'(10 + i));
    check("t2_occ_full", 32'(bus.occupancy), 32'd8);
    check("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
    check("t2_issue_valid", 32'(bus.dma_issue_valid), 32'd1);
    check("t2_issue_tag", 32'(bus.dma_issue_tag), 32'd0);
    set_desc(16'd18);
    tick(3);
    check("t2_held_ready", 32'(bus.in_ready), 32'd0);
    check("t2_held_occ", 32'(bus.occupancy), 32'd8);
    dma_auto = 1'b1;
    dma_lat  = 3;
    bus.dma_issue_ready = 1'b1;
    for (int t = 0; t < 100 && !bus.in_ready; t++) tick(1);
    check("t2_free_ready", 32'(bus.in_ready), 32'd1);
    check("t2_free_occ", 32'(bus.occupancy), 32'd7);
    tick(1);
    bus.in_valid = 1'b0;
    wait_done(300);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_retired", 32'(retired), 32'd9);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Out-of-order completions: tag 2 first, then 0 and 1.
    do_reset();
    bus.dma_issue_ready = 1'b1;
    bus.disp_ready      = 2'b11;
    start_frame(16'd3);
    for (int i = 0; i < 3; i++) send(16'(20 + i));
    tick(3);
    check("t3_occ", 32'(bus.occupancy), 32'd3);
    check("t3_all_issued", 32'(bus.dma_issue_valid), 32'd0);
    dma_q.push_back('{0, 3'd2});
    tick(4);
    check("t3_no_disp", 32'(bus.disp_valid), 32'd0);
    dma_q.push_back('{0, 3'd0});
    dma_q.push_back('{0, 3'd1});
    tick(1);
    check("t3_c0_valid", 32'(bus.disp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("t3_c%0d_valid", i + 1), 32'(bus.disp_valid), 32'd1);
      check($sformatf("t3_c%0d_gid", i + 1), 32'(bus.disp_gid[GID_W-1:0]), 32'(20 + i));
    end
    tick(1);
    check("t3_after_valid", 32'(bus.disp_valid), 32'd0);
    wait_done(50);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_err", 32'(bus.err_bad_tag), 32'd0);
    check("t3_retired", 32'(retired), 32'd3);

    // Both lanes stalled with three ready slots.
    do_reset();
    bus.dma_issue_ready = 1'b1;
    bus.disp_ready      = 2'b00;
    start_frame(16'd3);
    for (int i = 0; i < 3; i++) send(16'(30 + i));
    tick(3);
    for (int i = 0; i < 3; i++) dma_q.push_back('{0, 3'(i)});
    tick(8);
    check("t5_valid", 32'(bus.disp_valid), 32'd3);
    check("t5_lane0", 32'(bus.disp_gid[GID_W-1:0]), 32'd30);
    check("t5_lane1", 32'(bus.disp_gid[2*GID_W-1:GID_W]), 32'd31);
    check("t5_occ", 32'(bus.occupancy), 32'd1);
    bus.disp_ready = 2'b10;
    tick(1);
    check("t5_rel_valid", 32'(bus.disp_valid), 32'd3);
    check("t5_rel_lane1", 32'(bus.disp_gid[2*GID_W-1:GID_W]), 32'd32);
    check("t5_rel_lane0", 32'(bus.disp_gid[GID_W-1:0]), 32'd30);
    check("t5_rel_occ", 32'(bus.occupancy), 32'd0);
    bus.disp_ready = 2'b11;
    wait_done(50);
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_retired", 32'(retired), 32'd3);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Empty frame, then asynchronous reset in the middle of a drain.
    do_reset();
    start_frame(16'd0);
    check("t6_zero_done", 32'(bus.done), 32'd1);
    check("t6_zero_in_ready", 32'(bus.in_ready), 32'd0);
    do_reset();
    bus.dma_issue_ready = 1'b1;
    bus.disp_ready      = 2'b11;
    start_frame(16'd2);
    send(16'd40);
    send(16'd41);
    tick(2);
    check("t6_drain_in_ready", 32'(bus.in_ready), 32'd0);
    check("t6_drain_occ", 32'(bus.occupancy), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("t6_rst_issue_valid", 32'(bus.dma_issue_valid), 32'd0);
    check("t6_rst_disp_valid", 32'(bus.disp_valid), 32'd0);
    check("t6_rst_disp_gid", 32'(bus.disp_gid), 32'd0);
    check("t6_rst_occ", 32'(bus.occupancy), 32'd0);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    check("t6_rst_err", 32'(bus.err_bad_tag), 32'd0);
    tick(1);
    rst_n = 1'b1;
    dma_q.push_back('{0, 3'd0});
    tick(1);
    check("t6_stale_err", 32'(bus.err_bad_tag), 32'd1);
    check("t6_stale_occ", 32'(bus.occupancy), 32'd0);
    check("t6_idle_in_ready", 32'(bus.in_ready), 32'd0);
    check("t6_idle_done", 32'(bus.done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
